// File: rtl/serial_tx.sv
// MSB-first serial transmitter: parallel load, DIV cycles per bit, optional even parity,
// one-cycle done pulse, ready gating the next load. Outputs decode registered state only.
module serial_tx #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIV    = 2,
    parameter int unsigned PARITY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             sd,
    output logic             sen,
    output logic             done
);

    localparam int unsigned NBits = WIDTH + PARITY;
    localparam int unsigned BcW   = $clog2(NBits + 1);
    localparam int unsigned DcW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BcW-1:0] LastBit  = BcW'(NBits - 1);
    localparam logic [BcW-1:0] DataBits = BcW'(WIDTH);
    localparam logic [DcW-1:0] DivLast  = DcW'(DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DcW-1:0]   div_cnt_q, div_cnt_d;
    logic             par_q, par_d;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            par_q     <= par_d;
        end
    end

    // Next-state logic: load in idle, bit timing in shift, counters cleared in done.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        par_d     = par_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    par_d     = ^data_in;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BcW'(1);
                    // Final wrap and the move to done share one edge.
                    if (bit_cnt_q == LastBit) begin
                        state_d = StDone;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DcW'(1);
                end
            end
            StDone: begin
                bit_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready = (state_q == StIdle);
    assign sen   = (state_q == StShift);
    assign done  = (state_q == StDone);
    // Data bits come from the shifter MSB; the trailing slot (if any) carries parity.
    assign sd    = sen && ((bit_cnt_q < DataBits) ? shreg_q[WIDTH-1] : par_q);

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four instances in different configurations, a frame-offset model
// checked every cycle, plus literal waveform expectations for each scenario.
module tb_serial_tx;

    localparam int NCh = 4;
    localparam int CfgW [NCh] = '{8, 8, 8, 2};
    localparam int CfgD [NCh] = '{2, 1, 1, 3};
    localparam int CfgP [NCh] = '{0, 1, 0, 0};

    logic       clk;
    logic       rst_n;
    logic [3:0] load;
    logic [7:0] din [NCh];
    wire  [3:0] ready;
    wire  [3:0] sd;
    wire  [3:0] sen;
    wire  [3:0] done;

    int checks = 0;
    int errors = 0;

    // Model state: frame active flag, cycles since the accept edge, captured word.
    logic       m_active [NCh];
    int         m_t      [NCh];
    logic [7:0] m_data   [NCh];

    serial_tx #(.WIDTH(8), .DIV(2), .PARITY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .load(load[0]), .data_in(din[0]),
        .ready(ready[0]), .sd(sd[0]), .sen(sen[0]), .done(done[0])
    );
    serial_tx #(.WIDTH(8), .DIV(1), .PARITY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load[1]), .data_in(din[1]),
        .ready(ready[1]), .sd(sd[1]), .sen(sen[1]), .done(done[1])
    );
    serial_tx #(.WIDTH(8), .DIV(1), .PARITY(0)) u_c (
        .clk(clk), .rst_n(rst_n), .load(load[2]), .data_in(din[2]),
        .ready(ready[2]), .sd(sd[2]), .sen(sen[2]), .done(done[2])
    );
    serial_tx #(.WIDTH(2), .DIV(3), .PARITY(0)) u_d (
        .clk(clk), .rst_n(rst_n), .load(load[3]), .data_in(din[3][1:0]),
        .ready(ready[3]), .sd(sd[3]), .sen(sen[3]), .done(done[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {ready, sen, sd, done} for channel i, t cycles after its accept edge.
    function automatic logic [3:0] exp_out(int i, logic act, int t, logic [7:0] dat);
        int w;
        int len;
        int k;
        logic [7:0] msk;
        logic b;
        w   = CfgW[i];
        len = (CfgW[i] + CfgP[i]) * CfgD[i];
        if (!act) return 4'b1000;
        if (t < len) begin
            k   = t / CfgD[i];
            msk = 8'((1 << w) - 1);
            b   = (k < w) ? dat[w-1-k] : ^(dat & msk);
            return {1'b0, 1'b1, b, 1'b0};
        end
        return 4'b0001;
    endfunction

    // Model update on each clock edge and on reset assertion.
    initial begin
        for (int i = 0; i < NCh; i++) begin
            m_active[i] = 1'b0;
            m_t[i]      = 0;
            m_data[i]   = 8'h00;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < NCh; i++) begin
                if (!rst_n) begin
                    m_active[i] = 1'b0;
                    m_t[i]      = 0;
                end else if (!m_active[i]) begin
                    if (load[i]) begin
                        m_active[i] = 1'b1;
                        m_t[i]      = 0;
                        m_data[i]   = din[i];
                    end
                end else if (m_t[i] == (CfgW[i] + CfgP[i]) * CfgD[i]) begin
                    m_active[i] = 1'b0;
                end else begin
                    m_t[i] = m_t[i] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    initial begin
        logic [3:0] got;
        logic [3:0] expv;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCh; i++) begin
                got  = {ready[i], sen[i], sd[i], done[i]};
                expv = rst_n ? exp_out(i, m_active[i], m_t[i], m_data[i]) : 4'b1000;
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL cycle_ch%0d at %0t: got %b required %b (ready,sen,sd,done)",
                             i, $time, got, expv);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, expv);
        end
    endtask

    // Assert load; the next rising edge accepts it. Returns just after that edge.
    task automatic do_load(input int ch, input logic [7:0] v);
        din[ch]  = v;
        load[ch] = 1'b1;
        @(posedge clk);
        #1 load[ch] = 1'b0;
    endtask

    // Collect n falling-edge samples of one channel, earliest sample in the MSB.
    task automatic record(input int ch, input int n, output logic [31:0] sdv,
                          output logic [31:0] senv, output logic [31:0] rdyv,
                          output logic [31:0] donev);
        sdv = '0; senv = '0; rdyv = '0; donev = '0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            sdv   = {sdv[30:0], sd[ch]};
            senv  = {senv[30:0], sen[ch]};
            rdyv  = {rdyv[30:0], ready[ch]};
            donev = {donev[30:0], done[ch]};
        end
    endtask

    initial begin
        logic [31:0] v_sd, v_sen, v_rdy, v_done;
        rst_n = 1'b0;
        load  = 4'b0000;
        for (int i = 0; i < NCh; i++) din[i] = 8'h00;

        #1;
        chk("reset_ready", 32'(ready), 32'hF);
        chk("reset_sen", 32'(sen), 32'h0);
        chk("reset_sd", 32'(sd), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, DIV=2.
        do_load(0, 8'hA5);
        record(0, 18, v_sd, v_sen, v_rdy, v_done);
        chk("basic_sd", v_sd, 32'b110011000011001100);
        chk("basic_sen", v_sen, 32'b111111111111111100);
        chk("basic_done", v_done, 32'b000000000000000010);
        chk("basic_ready", v_rdy, 32'b000000000000000001);

        // Parity, DIV=1.
        do_load(1, 8'h07);
        record(1, 11, v_sd, v_sen, v_rdy, v_done);
        chk("par07_sd", v_sd, 32'b00000111100);
        chk("par07_sen", v_sen, 32'b11111111100);
        chk("par07_done", v_done, 32'b00000000010);
        do_load(1, 8'h03);
        record(1, 11, v_sd, v_sen, v_rdy, v_done);
        chk("par03_sd", v_sd, 32'b00000011000);

        // Load pulse during bit 3 of a zero frame must be dropped.
        do_load(0, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_ready", 32'(ready[0]), 32'h0);
        din[0]  = 8'hFF;
        load[0] = 1'b1;
        @(posedge clk);
        #1 load[0] = 1'b0;
        record(0, 14, v_sd, v_sen, v_rdy, v_done);
        chk("busy_sd", v_sd, 32'h0);
        chk("busy_sen", v_sen, 32'b11111111100000);
        chk("busy_done", v_done, 32'b00000000010000);

        // Back-to-back frames with load held high.
        din[2]  = 8'h80;
        load[2] = 1'b1;
        @(posedge clk);
        #1 din[2] = 8'h01;
        record(2, 20, v_sd, v_sen, v_rdy, v_done);
        load[2] = 1'b0;
        chk("b2b_sd", v_sd, 32'b10000000000000000100);
        chk("b2b_sen", v_sen, 32'b11111111001111111100);
        chk("b2b_ready", v_rdy, 32'b00000000010000000001);
        chk("b2b_done", v_done, 32'b00000000100000000010);
        repeat (3) @(posedge clk);
        #1;

        // Reset between edges during bit 4.
        do_load(0, 8'hFF);
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({ready[0], sen[0], sd[0], done[0]}), 32'b1000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        record(0, 4, v_sd, v_sen, v_rdy, v_done);
        chk("rst_no_done", v_done, 32'h0);
        chk("rst_idle_sen", v_sen, 32'h0);
        do_load(0, 8'h3C);
        record(0, 18, v_sd, v_sen, v_rdy, v_done);
        chk("rst_reload_sd", v_sd, 32'b000011111111000000);

        // WIDTH=2, DIV=3 boundary.
        do_load(3, 8'h02);
        record(3, 8, v_sd, v_sen, v_rdy, v_done);
        chk("wrap_sd", v_sd, 32'b11100000);
        chk("wrap_sen", v_sen, 32'b11111100);
        chk("wrap_done", v_done, 32'b00000010);
        chk("wrap_ready", v_rdy, 32'b00000001);
        chk("wrap_bitcnt", 32'(u_d.bit_cnt_q), 32'h0);
        chk("wrap_divcnt", 32'(u_d.div_cnt_q), 32'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
